ntt_ram_sched: RTL

- Sequences a full 256-point Kyber NTT or inverse NTT (q=3329) over one 12-bit x 512-entry true dual-port coefficient RAM.
- Each cycle it drives both RAM ports' addresses and write enables.
- Issues butterfly operand reads and the matching zeta index to the butterfly unit, then writes the results back in place after a fixed pipeline latency.
- Sits between the top-level accelerator FSM (start/done) and the RAM + butterfly datapath; it handles address and control only and never touches data.

---
 rtl/ntt_ram_sched.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ntt_ram_sched.sv
// ntt_ram_sched
// Address/control sequencer for one 256-point Kyber NTT (forward, CT) or
// inverse NTT (GS) over a 12-bit x 512-entry true dual-port coefficient RAM.
// It issues butterfly operand reads on even slots and writes the results
// back in place BF_LAT cycles later. Writes always land on odd slots. It
// never touches coefficient data.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               begin a transform (ignored unless idle)
//   inverse_i             0 = forward NTT, 1 = inverse NTT (latched on start)
//   poly_sel_i            RAM half, drives address bit 8 (latched on start)
//   ram_addr_a_o/_b_o     RAM port addresses
//   ram_we_a_o/_b_o       RAM port write enables
//   bf_valid_o            RAM outputs hold a valid operand pair this cycle
//   bf_inv_o, zeta_idx_o  butterfly mode and twiddle index, aligned to bf_valid_o
//   busy_o                transform in progress
//   done_o                one-cycle completion pulse
module ntt_ram_sched #(
    parameter int BF_LAT = 5,
    parameter int N_LOG  = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       inverse_i,
    input  logic       poly_sel_i,
    output logic [8:0] ram_addr_a_o,
    output logic [8:0] ram_addr_b_o,
    output logic       ram_we_a_o,
    output logic       ram_we_b_o,
    output logic       bf_valid_o,
    output logic       bf_inv_o,
    output logic [6:0] zeta_idx_o,
    output logic       busy_o,
    output logic       done_o
);

    // Odd latency keeps writes on odd slots, away from the even read slots.
    if (BF_LAT < 3 || (BF_LAT % 2) == 0 || N_LOG != 8) begin : g_param_check
        $fatal(1, "ntt_ram_sched: BF_LAT must be odd and >= 3, N_LOG must be 8");
    end

    // One layer: 128 reads on even slots 0..254, last write at slot P-1.
    localparam int P  = 255 + BF_LAT;
    localparam int CW = $clog2(P + 1);
    localparam logic [CW-1:0] LAST_CYC = CW'(P - 1);
    localparam logic [CW-1:0] LAST_RD  = CW'(254);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t          state_q;
    logic            inv_q;
    logic            poly_q;
    logic [2:0]      layer_q;
    logic [CW-1:0]   cyc_q;

    // Write-back delay line: pipe[k] holds the pair read k cycles ago.
    logic [BF_LAT-1:0] pipe_v_q;
    logic [8:0]        pipe_a_q [BF_LAT];
    logic [8:0]        pipe_b_q [BF_LAT];

    // Read currently on the RAM ports, remembered to align bf_* one cycle later.
    logic            rd_now_q;
    logic [6:0]      rd_zeta_q;
    logic            rd_inv_q;

    logic [8:0]      addr_a_q, addr_b_q;
    logic            we_q, bf_valid_q, bf_inv_q, busy_q, done_q;
    logic [6:0]      zeta_q;

    logic            new_s, adv_s, last_s, rd_en_s, mode_inv_s, mode_poly_s;
    logic [CW-1:0]   nxt_cyc_s;
    logic [2:0]      nxt_layer_s, lg_s;
    logic [3:0]      sh_s;
    logic [6:0]      rd_idx_s, grp_s, len_m1_s, zeta_s;
    logic [7:0]      len_s, j_s, jb_s;

    // Next-cycle slot position and the read pair/twiddle scheduled for it.
    always_comb begin
        new_s       = (state_q == IDLE) && start_i;
        adv_s       = new_s || (state_q == RUN) || (state_q == DRAIN);
        last_s      = ((state_q == RUN) || (state_q == DRAIN)) &&
                      (cyc_q == LAST_CYC) && (layer_q == 3'd6);
        mode_inv_s  = new_s ? inverse_i  : inv_q;
        mode_poly_s = new_s ? poly_sel_i : poly_q;
        if (new_s) begin
            nxt_cyc_s   = '0;
            nxt_layer_s = 3'd0;
        end else if (cyc_q == LAST_CYC) begin
            nxt_cyc_s   = '0;
            nxt_layer_s = layer_q + 3'd1;
        end else begin
            nxt_cyc_s   = cyc_q + CW'(1);
            nxt_layer_s = layer_q;
        end
        rd_en_s  = adv_s && !last_s && !nxt_cyc_s[0] && (nxt_cyc_s <= LAST_RD);
        rd_idx_s = nxt_cyc_s[7:1];
        // log2(len): forward 7..1, inverse 1..7
        lg_s     = mode_inv_s ? (nxt_layer_s + 3'd1) : (3'd7 - nxt_layer_s);
        sh_s     = {1'b0, lg_s} + 4'd1;
        len_s    = 8'd1 << lg_s;
        len_m1_s = 7'h7F >> (3'd7 - lg_s);
        grp_s    = rd_idx_s >> lg_s;
        // j = group * 2*len + offset within group; partner at j+len
        j_s      = ({1'b0, grp_s} << sh_s) | {1'b0, rd_idx_s & len_m1_s};
        jb_s     = j_s + len_s;
        // Twiddle index continues across layers: forward 1..127, inverse 127..1.
        if (mode_inv_s) begin
            zeta_s = (7'd127 >> nxt_layer_s) - grp_s;
        end else begin
            zeta_s = (7'd1 << nxt_layer_s) + grp_s;
        end
    end

    // Sequencer state, write-back delay line and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            inv_q      <= 1'b0;
            poly_q     <= 1'b0;
            layer_q    <= 3'd0;
            cyc_q      <= '0;
            pipe_v_q   <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                pipe_a_q[i] <= 9'd0;
                pipe_b_q[i] <= 9'd0;
            end
            rd_now_q   <= 1'b0;
            rd_zeta_q  <= 7'd0;
            rd_inv_q   <= 1'b0;
            addr_a_q   <= 9'd0;
            addr_b_q   <= 9'd0;
            we_q       <= 1'b0;
            bf_valid_q <= 1'b0;
            bf_inv_q   <= 1'b0;
            zeta_q     <= 7'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pipe_v_q    <= {pipe_v_q[BF_LAT-2:0], rd_en_s};
            pipe_a_q[0] <= {mode_poly_s, j_s};
            pipe_b_q[0] <= {mode_poly_s, jb_s};
            for (int i = 1; i < BF_LAT; i++) begin
                pipe_a_q[i] <= pipe_a_q[i-1];
                pipe_b_q[i] <= pipe_b_q[i-1];
            end

            rd_now_q  <= rd_en_s;
            rd_zeta_q <= rd_en_s ? zeta_s : 7'd0;
            rd_inv_q  <= rd_en_s ? mode_inv_s : 1'b0;

            if (rd_en_s) begin
                addr_a_q <= {mode_poly_s, j_s};
                addr_b_q <= {mode_poly_s, jb_s};
                we_q     <= 1'b0;
            end else if (pipe_v_q[BF_LAT-1]) begin
                addr_a_q <= pipe_a_q[BF_LAT-1];
                addr_b_q <= pipe_b_q[BF_LAT-1];
                we_q     <= 1'b1;
            end else begin
                addr_a_q <= 9'd0;
                addr_b_q <= 9'd0;
                we_q     <= 1'b0;
            end

            bf_valid_q <= rd_now_q;
            bf_inv_q   <= rd_inv_q;
            zeta_q     <= rd_zeta_q;
            done_q     <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= RUN;
                        inv_q   <= inverse_i;
                        poly_q  <= poly_sel_i;
                        cyc_q   <= '0;
                        layer_q <= 3'd0;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    if (last_s) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= (nxt_cyc_s <= LAST_RD) ? RUN : DRAIN;
                        cyc_q   <= nxt_cyc_s;
                        layer_q <= nxt_layer_s;
                        busy_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ram_addr_a_o = addr_a_q;
    assign ram_addr_b_o = addr_b_q;
    assign ram_we_a_o   = we_q;
    assign ram_we_b_o   = we_q;
    assign bf_valid_o   = bf_valid_q;
    assign bf_inv_o     = bf_inv_q;
    assign zeta_idx_o   = zeta_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
